// File: rtl/ym_bus_pkg.sv
// Shared types and defaults for the host write-port bridge.
package ym_bus_pkg;

    localparam int unsigned ENTRY_W             = 9;
    localparam int unsigned DEPTH_DEFAULT       = 4;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    // One queued host write: register-select bit plus data byte.
    typedef struct packed {
        logic       a0;
        logic [7:0] data;
    } entry_t;

endpackage

// File: rtl/ym_bus_if_if.sv
// Host-bus and synth-side write handshake bundle for ym_bus_if.
interface ym_bus_if_if;

    logic       bus_cs_n;
    logic       bus_wr_n;
    logic       bus_a0;
    logic [7:0] bus_din;
    logic       wr_valid;
    logic       wr_a0;
    logic [7:0] wr_data;
    logic       wr_ready;

    // Bridge side: consumes the host bus, presents the queue head.
    modport slave (
        input  bus_cs_n, bus_wr_n, bus_a0, bus_din, wr_ready,
        output wr_valid, wr_a0, wr_data
    );

    // Host / synth-core side.
    modport master (
        output bus_cs_n, bus_wr_n, bus_a0, bus_din, wr_ready,
        input  wr_valid, wr_a0, wr_data
    );

endinterface

// File: rtl/ym_wr_fifo.sv
// Write queue: FIFO of host writes with level count and sticky overflow.
module ym_wr_fifo
    import ym_bus_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  entry_t           push_entry,
    input  logic             pop,
    input  logic             overflow_clr,
    output entry_t           head,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             push_ok, pop_ok, drop;

    // Next-state: a push into a full queue is accepted only when a pop frees a slot.
    always_comb begin
        full       = (level_q == LVL_W'(DEPTH));
        empty      = (level_q == '0);
        pop_ok     = pop & ~empty;
        push_ok    = push & (~full | pop_ok);
        drop       = push & full & ~pop_ok;

        mem_d = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_entry;
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);

        level_d = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        // A drop on the same edge as a clear leaves the flag set.
        overflow_d = drop | (overflow_q & ~overflow_clr);
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    assign head     = mem_q[rd_ptr_q];
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/ym_bus_if.sv
// Host write-port bridge: synchronises the async host bus, captures each
// write into a holding register and pushes it into the write queue on the
// rising edge of the write strobe.
module ym_bus_if
    import ym_bus_pkg::*;
#(
    parameter int unsigned DEPTH       = DEPTH_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ym_bus_if_if.slave             bus,
    input  logic                   overflow_clr,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);

    localparam int unsigned TOP = SYNC_STAGES - 1;

    logic [SYNC_STAGES-1:0]      cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0]      wr_sync_q, wr_sync_d;
    logic [SYNC_STAGES-1:0]      a0_pipe_q, a0_pipe_d;
    logic [SYNC_STAGES-1:0][7:0] din_pipe_q, din_pipe_d;
    logic                        wr_prev_q, wr_prev_d;
    logic                        armed_q, armed_d;
    entry_t                      hold_q, hold_d;

    logic   cs_s, wr_s, load, strobe;
    entry_t head;
    logic   fifo_full, fifo_empty;

    // a0/din travel through chains as deep as the cs/wr synchronisers so the
    // captured data lines up with the synced strobe samples.
    always_comb begin
        cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], bus.bus_cs_n};
        wr_sync_d  = {wr_sync_q[SYNC_STAGES-2:0], bus.bus_wr_n};
        a0_pipe_d  = {a0_pipe_q[SYNC_STAGES-2:0], bus.bus_a0};
        din_pipe_d[0] = bus.bus_din;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            din_pipe_d[i] = din_pipe_q[i-1];
        end

        cs_s   = cs_sync_q[TOP];
        wr_s   = wr_sync_q[TOP];
        load   = ~wr_s & ~cs_s;
        strobe = wr_s & ~wr_prev_q & armed_q;

        hold_d = hold_q;
        if (load) begin
            hold_d.a0   = a0_pipe_q[TOP];
            hold_d.data = din_pipe_q[TOP];
        end

        armed_d = armed_q;
        if (load) begin
            armed_d = 1'b1;
        end else if (strobe) begin
            armed_d = 1'b0;
        end

        wr_prev_d = wr_s;
    end

    // Synchroniser, holding-register and strobe-history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q  <= '1;
            wr_sync_q  <= '1;
            a0_pipe_q  <= '0;
            din_pipe_q <= '0;
            wr_prev_q  <= 1'b1;
            armed_q    <= 1'b0;
            hold_q     <= '0;
        end else begin
            cs_sync_q  <= cs_sync_d;
            wr_sync_q  <= wr_sync_d;
            a0_pipe_q  <= a0_pipe_d;
            din_pipe_q <= din_pipe_d;
            wr_prev_q  <= wr_prev_d;
            armed_q    <= armed_d;
            hold_q     <= hold_d;
        end
    end

    ym_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push         (strobe),
        .push_entry   (hold_q),
        .pop          (bus.wr_ready),
        .overflow_clr (overflow_clr),
        .head         (head),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .level        (level),
        .overflow     (overflow)
    );

    assign bus.wr_valid = ~fifo_empty;
    assign bus.wr_a0    = head.a0;
    assign bus.wr_data  = head.data;

endmodule
